// File: rtl/fetch_queue.sv
// fetch_queue: PC-tracking instruction queue between fetch and decode.
// Drops duplicate and wrong-path fetch entries; FWFT valid/ready output.
`default_nettype none

module fetch_queue #(
  parameter int DEPTH = 8,
  parameter int SKID  = 2,
  parameter int XLEN  = 32
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic [XLEN-1:0]          in_pc_i,
  input  logic [XLEN-1:0]          in_inst_i,
  input  logic                     in_valid_i,
  output logic                     stall_o,
  input  logic                     redirect_i,
  input  logic [XLEN-1:0]          redirect_pc_i,
  output logic [XLEN-1:0]          out_pc_o,
  output logic [XLEN-1:0]          out_inst_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0] C_STALL = (AW+1)'(DEPTH - SKID);

  typedef enum logic [0:0] {
    SYNC = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [XLEN-1:0] exp_pc_q, exp_pc_d;
  logic            stall_q, stall_d;

  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [XLEN-1:0] inst_mem [DEPTH];

  logic pop, push, push_ok, pc_match;

  assign out_valid_o = (count_q != '0);
  assign pop         = out_valid_o && out_ready_i && !redirect_i;
  assign push_ok     = (count_q < C_FULL) || (out_valid_o && out_ready_i);
  assign pc_match    = (state_q == SYNC) || (in_pc_i == exp_pc_q);
  assign push        = in_valid_i && pc_match && push_ok && !redirect_i;

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    exp_pc_d = exp_pc_q;
    stall_d  = stall_q;
    if (redirect_i) begin
      // Flush: all in-flight and buffered entries are wrong-path.
      state_d  = RUN;
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
      exp_pc_d = redirect_pc_i;
      stall_d  = 1'b0;
    end else begin
      if (push) begin
        state_d  = RUN;
        wr_ptr_d = wr_ptr_q + AW'(1);
        exp_pc_d = in_pc_i + XLEN'(4);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
      stall_d = (count_d >= C_STALL);
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= SYNC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      exp_pc_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      exp_pc_q <= exp_pc_d;
      stall_q  <= stall_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= in_pc_i;
      inst_mem[wr_ptr_q] <= in_inst_i;
    end
  end

  assign out_pc_o   = out_valid_o ? pc_mem[rd_ptr_q]   : '0;
  assign out_inst_o = out_valid_o ? inst_mem[rd_ptr_q] : '0;
  assign stall_o    = stall_q;
  assign count_o    = count_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed stimulus with a scoreboard queue of expected PCs
// popped by an independent monitor on every decode handshake.
`default_nettype none

module tb_fetch_queue;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic [31:0] in_pc_i, in_inst_i, redirect_pc_i;
  logic        in_valid_i, redirect_i, out_ready_i;
  logic        stall_o, out_valid_o;
  logic [31:0] out_pc_o, out_inst_o;
  logic [3:0]  count_o;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q [$];

  fetch_queue #(.DEPTH(8), .SKID(2), .XLEN(32)) dut (
    .clk_i         (clk_i),
    .reset_ni      (reset_ni),
    .in_pc_i       (in_pc_i),
    .in_inst_i     (in_inst_i),
    .in_valid_i    (in_valid_i),
    .stall_o       (stall_o),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .out_pc_o      (out_pc_o),
    .out_inst_o    (out_inst_o),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .count_o       (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every decode handshake consumes the oldest expected entry.
  always @(negedge clk_i) begin
    if (reset_ni && out_valid_o && out_ready_i && !redirect_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pop: got pc 0x%08h expected none", out_pc_o);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("pop_pc", out_pc_o, e);
        chk("pop_inst", out_inst_o, ~e);
      end
    end
  end

  // One fetch cycle; acc marks an entry the DUT is required to accept.
  task automatic drive(input logic v, input logic [31:0] pc, input logic rdy,
                       input logic rd, input logic [31:0] rpc, input bit acc);
    in_valid_i    = v;
    in_pc_i       = pc;
    in_inst_i     = ~pc;
    out_ready_i   = rdy;
    redirect_i    = rd;
    redirect_pc_i = rpc;
    if (acc) exp_q.push_back(pc);
    @(posedge clk_i);
    #1;
    if (rd) exp_q.delete();
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 32'h0, rdy, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_ni = 1'b0;
    in_valid_i = 0; in_pc_i = 0; in_inst_i = 0;
    out_ready_i = 0; redirect_i = 0; redirect_pc_i = 0;
    #23;
    chk("rst_valid", {31'b0, out_valid_o}, 32'd0);
    chk("rst_stall", {31'b0, stall_o}, 32'd0);
    chk("rst_count", {28'b0, count_o}, 32'd0);
    chk("rst_pc", out_pc_o, 32'd0);
    @(posedge clk_i); #1;
    reset_ni = 1'b1;

    // Stream with decode ready: occupancy holds at 1.
    drive(1, 32'd4, 1, 0, 0, 1);
    chk("t1_count_first", {28'b0, count_o}, 32'd1);
    chk("t1_head", out_pc_o, 32'd4);
    for (int p = 8; p <= 16; p += 4) begin
      drive(1, p, 1, 0, 0, 1);
      chk("t1_count_steady", {28'b0, count_o}, 32'd1);
    end
    idle(1);
    chk("t1_drained", {28'b0, count_o}, 32'd0);

    // Fill with decode stalled; repeats of the last PC are dropped.
    for (int p = 20; p <= 40; p += 4) drive(1, p, 0, 0, 0, 1);
    chk("t2_count6", {28'b0, count_o}, 32'd6);
    chk("t2_stall", {31'b0, stall_o}, 32'd1);
    for (int i = 0; i < 3; i++) drive(1, 32'd40, 0, 0, 0, 0);
    chk("t2_repeat_dropped", {28'b0, count_o}, 32'd6);
    drive(1, 32'd44, 0, 0, 0, 1);
    drive(1, 32'd48, 0, 0, 0, 1);
    chk("t2_full", {28'b0, count_o}, 32'd8);
    drive(1, 32'd52, 0, 0, 0, 0);
    chk("t4_full_drop", {28'b0, count_o}, 32'd8);
    drive(1, 32'd52, 1, 0, 0, 1);
    chk("t4_push_pop_full", {28'b0, count_o}, 32'd8);
    drive(1, 32'd56, 0, 0, 0, 0);
    drive(1, 32'd56, 1, 0, 0, 1);
    chk("t4_exp_unchanged", {28'b0, count_o}, 32'd8);
    for (int i = 0; i < 8; i++) idle(1);
    chk("t2_drain_count", {28'b0, count_o}, 32'd0);
    chk("t2_drain_stall", {31'b0, stall_o}, 32'd0);

    // Redirect with 5 buffered entries.
    for (int p = 60; p <= 76; p += 4) drive(1, p, 0, 0, 0, 1);
    chk("t3_count5", {28'b0, count_o}, 32'd5);
    drive(0, 32'd0, 0, 1, 32'h80, 0);
    chk("t3_flush_count", {28'b0, count_o}, 32'd0);
    chk("t3_flush_valid", {31'b0, out_valid_o}, 32'd0);
    drive(1, 32'h24, 1, 0, 0, 0);
    chk("t3_stale_dropped", {28'b0, count_o}, 32'd0);
    drive(1, 32'h80, 1, 0, 0, 1);
    chk("t3_target_head", out_pc_o, 32'h80);
    idle(1);

    // Redirect in the same cycle as push and pop.
    drive(1, 32'h84, 0, 0, 0, 1);
    drive(1, 32'h88, 0, 0, 0, 1);
    drive(1, 32'h8C, 1, 1, 32'h100, 0);
    chk("t5_count", {28'b0, count_o}, 32'd0);
    chk("t5_valid", {31'b0, out_valid_o}, 32'd0);
    chk("t5_stall", {31'b0, stall_o}, 32'd0);
    drive(1, 32'h100, 1, 0, 0, 1);
    chk("t5_target_head", out_pc_o, 32'h100);
    idle(1);

    // Asynchronous reset between edges while stalled.
    for (int p = 32'h104; p <= 32'h118; p += 4) drive(1, p, 0, 0, 0, 1);
    chk("t6_pre_stall", {31'b0, stall_o}, 32'd1);
    #3;
    reset_ni = 1'b0;
    #1;
    exp_q.delete();
    chk("t6_async_valid", {31'b0, out_valid_o}, 32'd0);
    chk("t6_async_stall", {31'b0, stall_o}, 32'd0);
    chk("t6_async_count", {28'b0, count_o}, 32'd0);
    @(posedge clk_i); #1;
    reset_ni = 1'b1;
    drive(1, 32'h40, 1, 0, 0, 1);
    chk("t6_sync_accept", out_pc_o, 32'h40);
    chk("t6_sync_count", {28'b0, count_o}, 32'd1);
    idle(1);
    idle(1);
    chk("sb_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Instruction fetch queue between the fetch stage and decode. Accepts the registered fetch outputs (pc, instruction, valid) and filters out duplicate and wrong-path entries by PC tracking. Buffers accepted entries in a FIFO and presents them to decode over a valid/ready handshake. Drives the fetch stall input, and flushes on a branch redirect.

Parameters:
DEPTH, 8, number of entries; power of 2, minimum 4
SKID, 2, entries reserved for fetch in-flight latency; stall_o asserts when free slots are SKID or fewer
XLEN, 32, PC and instruction width

Ports:
clk_i  in  1  clock, rising edge
reset_ni  in  1  asynchronous active-low reset
in_pc_i  in  XLEN  PC from fetch
in_inst_i  in  XLEN  instruction from fetch
in_valid_i  in  1  fetch output valid
stall_o  out  1  to fetch stall input; holds the fetch PC
redirect_i  in  1  branch redirect; same cycle as the fetch pc_sel pulse
redirect_pc_i  in  XLEN  redirect target; same value as the fetch br_dest
out_pc_o  out  XLEN  head entry PC
out_inst_o  out  XLEN  head entry instruction
out_valid_o  out  1  head entry valid (count != 0)
out_ready_i  in  1  decode accepts head
count_o  out  log2(DEPTH)+1  occupancy

Behaviour:
- Reset (async, reset_ni=0): count=0; rd_ptr=wr_ptr=0; expected_pc=0; state=SYNC. Outputs: out_valid_o=0, stall_o=0, out_pc_o=0, out_inst_o=0, count_o=0. Storage array is not reset. Reset mid-operation discards all entries immediately.
- Tracking FSM, two states:
  - SYNC: the first cycle with in_valid_i=1 and a non-full queue accepts the entry regardless of PC, sets expected_pc=in_pc_i+4, and moves to RUN.
  - RUN: an entry is accepted only when in_valid_i=1, in_pc_i==expected_pc, and push is allowed. On accept, expected_pc<=in_pc_i+4, modulo 2^XLEN with wrap.
  - In RUN, any valid entry with a mismatching PC is silently dropped. This removes repeated PCs while fetch is stalled and in-flight wrong-path entries after a redirect.
- Redirect: redirect_i=1 empties the queue on the next edge (count=0, rd_ptr=wr_ptr). It also sets expected_pc=redirect_pc_i and state=RUN.
  - Redirect has priority over any push and pop in the same cycle. The input entry and the decode handshake in that cycle are ignored, and the head is not consumed.
  - out_valid_o=0 in the cycle after a redirect.
- Push allowed: count<DEPTH, or count==DEPTH with a pop in the same cycle. A matching entry that arrives while push is disallowed is dropped and expected_pc is not advanced. SKID sizing guarantees this does not occur when fetch honours stall_o.
- Pop: out_valid_o && out_ready_i; rd_ptr advances.
  - Simultaneous push and pop leave count unchanged.
  - Pointers wrap modulo DEPTH.
- Output is first-word fall-through: out_pc_o/out_inst_o show storage[rd_ptr] combinationally. Contents are don't-care when out_valid_o=0.
- stall_o is registered: stall_o <= (next_count >= DEPTH-SKID). It is 0 during reset and 0 in the cycle after a redirect.
- Latency: an entry accepted at edge N is visible at the output after edge N (out_valid_o high in cycle N+1). Minimum fetch-to-decode latency is 1 cycle.
- Throughput: 1 entry per cycle in and out when non-full and decode is ready.

Test Plan:
1. Release reset. Fetch streams pc 4,8,12… with valid=1, out_ready_i=1 -> SYNC locks on pc=4; decode sees 4,8,12 in order, one per cycle, with 1-cycle latency; count_o holds at 1.
2. out_ready_i=0 and fetch streams -> count reaches 6 and stall_o=1. While stalled, fetch repeats pc=0x1C -> the repeats are dropped and count stays at or below 8 (no overflow). Then out_ready_i=1 -> drain order is contiguous PCs with no gaps or duplicates.
3. Queue holds 5 entries and redirect_i=1 with redirect_pc_i=0x80. The next cycle fetch presents stale pc 0x24, then 0x80 -> count=0 after the edge; 0x24 is dropped; 0x80 is accepted and becomes the next out_pc_o.
4. Queue full (count=8), push of the expected PC with out_ready_i=1 in the same cycle -> push and pop both occur and count stays at 8. The same push with out_ready_i=0 -> entry dropped, expected_pc unchanged.
5. Redirect asserted in the same cycle as a valid push and out_ready_i=1 -> queue empty and no entry delivered. The popped head is not counted as consumed.
6. Assert reset_ni=0 asynchronously mid-stream between clock edges -> out_valid_o, stall_o, and count_o drop to 0 immediately. After release, state=SYNC and the first valid PC is accepted whatever its value, e.g. 0x40.
